// File: rtl/mov_pkg.sv
// Shared constants and the writeback entry type for the 64-bit MOV writeback stage.
package mov_pkg;

    localparam int MOV_DW       = 64;
    localparam int MOV_AW       = 5;
    localparam int MOV_WB_DEPTH = 4;

    typedef struct packed {
        logic [MOV_AW-1:0] rd;
        logic [MOV_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mov_wb_64_if.sv
// Register-file write port: request/acknowledge handshake carrying one write.
interface mov_wb_64_if
    import mov_pkg::*;
#(
    parameter int DW = MOV_DW,
    parameter int AW = MOV_AW
) ();

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
    modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);

endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with registered count/full/empty; a push into a full
// FIFO is accepted only when a pop completes in the same cycle.
module wb_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dout,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          w_do_push;
    logic          w_do_pop;
    logic [CW-1:0] w_count_nxt;

    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // NOTE: storage is not reset; stale words are unreachable once pointers and
    // count are cleared, and the consumer masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: rtl/mov_wb_64.sv
// Writeback end of the MOV pipeline: buffers results and writes them to the register file.
// Build option MOV_WB_BYPASS_EN: an empty FIFO forwards the incoming result combinationally.
module mov_wb_64
    import mov_pkg::*;
#(
    parameter int DW    = MOV_DW,
    parameter int AW    = MOV_AW,
    parameter int DEPTH = MOV_WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    input  logic [AW-1:0]          in_rd,
    mov_wb_64_if.master            wr,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);
    logic [AW+DW-1:0] w_head;
    logic [AW+DW-1:0] w_head_masked;
    logic             w_empty;
    logic             w_in_ok;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             r_ovf;

    // Register 0 is hard-wired, so results targeting it are simply dropped.
    assign w_in_ok = in_valid && (in_rd != '0);

`ifdef MOV_WB_BYPASS_EN
    assign w_bypass = w_in_ok && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed result that is acknowledged at once never occupies a slot.
    assign w_push = w_in_ok && !(w_bypass && wr.wr_ack);
    assign w_pop  = !w_empty && wr.wr_ack;

    wb_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({in_rd, in_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (full),
        .o_count (count)
    );

    assign w_head_masked = w_empty ? '0 : w_head;

    assign wr.wr_req = !w_empty || w_bypass;
    assign {wr.wr_addr, wr.wr_data} = w_bypass ? {in_rd, in_data} : w_head_masked;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_push && full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;

endmodule

// File: tb/tb_mov_wb_64.sv
// Self-checking bench for mov_wb_64: directed scenarios plus a randomized run
// against a queue-based model of the writeback buffer.
module tb_mov_wb_64;
    import mov_pkg::*;

    localparam int DEPTH = MOV_WB_DEPTH;
`ifdef MOV_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 0 : 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [4:0]  in_rd;
    logic        full;
    logic [2:0]  count;
    logic        ovf;

    mov_wb_64_if #(.DW(64), .AW(5)) wr_if ();

    mov_wb_64 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_rd    (in_rd),
        .wr       (wr_if),
        .full     (full),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  got_q[$];

    function automatic logic [63:0] pattern(input logic [4:0] rd);
        return 64'(rd) * 64'h0101_0101_0101_0101 + 64'h0F00_0000_0000_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] rd, input logic [63:0] d, input bit ack);
        in_valid     = v;
        in_rd        = rd;
        in_data      = d;
        wr_if.wr_ack = ack;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Holds wr_ack high and records the address of every transfer, checking its data.
    task automatic drain(input int cycles);
        got_q.delete();
        drive(1'b0, '0, '0, 1'b1);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (wr_if.wr_req) begin
                got_q.push_back(wr_if.wr_addr);
                n_checks++;
                if (wr_if.wr_data !== pattern(wr_if.wr_addr)) begin
                    n_fail++;
                    $display("FAIL drain_data: rd=%0d got %h want %h", wr_if.wr_addr,
                             wr_if.wr_data, pattern(wr_if.wr_addr));
                end
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (wr_if.wr_req !== 1'b0 || count !== 3'd0 || full !== 1'b0 || ovf !== 1'b0 ||
            wr_if.wr_addr !== 5'd0 || wr_if.wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b count=%0d full=%b ovf=%b addr=%0d data=%h, want all zero",
                     wr_if.wr_req, count, full, ovf, wr_if.wr_addr, wr_if.wr_data);
        end
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), pattern(5'(i)), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (count !== 3'd3 || wr_if.wr_req !== 1'b1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: count=%0d req=%b ovf=%b, want 3 1 1", count, wr_if.wr_req, ovf);
        end
        tick();
        drive(1'b1, 5'd6, pattern(5'd6), 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (count !== 3'd0 || wr_if.wr_req !== 1'b0 || ovf !== 1'b0 || full !== 1'b0 ||
            wr_if.wr_addr !== 5'd0 || wr_if.wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d req=%b ovf=%b full=%b addr=%0d data=%h, want all zero",
                     count, wr_if.wr_req, ovf, full, wr_if.wr_addr, wr_if.wr_data);
        end
        tick();
        drive(1'b1, 5'd7, 64'hA5A5, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (wr_if.wr_req !== 1'b1 || wr_if.wr_addr !== 5'd7 || wr_if.wr_data !== 64'hA5A5 ||
            count !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: req=%b addr=%0d data=%h count=%0d, want 1 7 a5a5 1",
                     wr_if.wr_req, wr_if.wr_addr, wr_if.wr_data, count);
        end
        tick();
        drive(1'b0, '0, '0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (count !== 3'd0 || wr_if.wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pop: count=%0d req=%b, want 0 0", count, wr_if.wr_req);
        end
    endtask

    task automatic test_single_push();
        int hits = 0;
        int hit_cyc = -1;
        do_reset();
        drive(1'b1, 5'd3, 64'h1111_1111_1111_1111, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wr_if.wr_req) begin
                hits++;
                hit_cyc = c;
                n_checks++;
                if (wr_if.wr_addr !== 5'd3 || wr_if.wr_data !== 64'h1111_1111_1111_1111) begin
                    n_fail++;
                    $display("FAIL single_payload: addr=%0d data=%h, want 3 1111111111111111",
                             wr_if.wr_addr, wr_if.wr_data);
                end
            end
            tick();
            drive(1'b0, '0, '0, 1'b1);
        end
        drive(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (hits != 1 || hit_cyc != LAT) begin
            n_fail++;
            $display("FAIL single_latency: %0d write cycles at cycle %0d, want 1 at cycle %0d",
                     hits, hit_cyc, LAT);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), pattern(5'(i)), 1'b0);
            tick();
            n_checks++;
            if (count !== 3'((i > 4) ? 4 : i) || full !== (i >= 4) || ovf !== (i == 5)) begin
                n_fail++;
                $display("FAIL fill_%0d: count=%0d full=%b ovf=%b, want %0d %b %b", i, count, full,
                         ovf, (i > 4) ? 4 : i, i >= 4, i == 5);
            end
        end
        drain(8);
        n_checks++;
        if (got_q.size() != 4 || got_q[0] !== 5'd1 || got_q[1] !== 5'd2 ||
            got_q[2] !== 5'd3 || got_q[3] !== 5'd4) begin
            n_fail++;
            $display("FAIL overflow_order: got %p, want '{1,2,3,4}", got_q);
        end
        n_checks++;
        if (count !== 3'd0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: count=%0d ovf=%b, want 0 1", count, ovf);
        end
    endtask

    task automatic test_full_swap();
        do_reset();
        for (int i = 11; i <= 14; i++) begin
            drive(1'b1, 5'(i), pattern(5'(i)), 1'b0);
            tick();
        end
        drive(1'b1, 5'd9, pattern(5'd9), 1'b1);
        @(negedge clk);
        n_checks++;
        if (wr_if.wr_req !== 1'b1 || wr_if.wr_addr !== 5'd11 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_head: req=%b addr=%0d full=%b, want 1 11 1", wr_if.wr_req,
                     wr_if.wr_addr, full);
        end
        tick();
        drive(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (count !== 3'd4 || full !== 1'b1 || ovf !== 1'b0 || wr_if.wr_addr !== 5'd12) begin
            n_fail++;
            $display("FAIL swap_state: count=%0d full=%b ovf=%b addr=%0d, want 4 1 0 12", count,
                     full, ovf, wr_if.wr_addr);
        end
        drain(8);
        n_checks++;
        if (got_q.size() != 4 || got_q[0] !== 5'd12 || got_q[1] !== 5'd13 ||
            got_q[2] !== 5'd14 || got_q[3] !== 5'd9) begin
            n_fail++;
            $display("FAIL swap_order: got %p, want '{12,13,14,9}", got_q);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1'b1, 5'd0, 64'hFFFF, 1'b0);
        @(negedge clk);
        n_checks++;
        if (wr_if.wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_req_now: req=%b, want 0", wr_if.wr_req);
        end
        tick();
        drive(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (count !== 3'd0 || wr_if.wr_req !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: count=%0d req=%b ovf=%b, want 0 0 0", count, wr_if.wr_req, ovf);
        end
    endtask

    task automatic test_random();
        wb_entry_t  q[$];
        wb_entry_t  exp_e;
        bit         m_ovf = 1'b0;
        bit         v, ack, byp, exp_req, consumed;
        logic [4:0] rd;
        logic [63:0] d;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            v   = 1'($urandom % 2);
            rd  = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d   = {$urandom, $urandom};
            ack = 1'($urandom % 2);
            drive(v, rd, d, ack);
            @(negedge clk);
            byp     = BYP && v && (rd != 5'd0) && (q.size() == 0);
            exp_req = (q.size() != 0) || byp;
            if (q.size() != 0) begin
                exp_e = q[0];
            end else begin
                exp_e.rd   = rd;
                exp_e.data = d;
            end
            n_checks++;
            if (wr_if.wr_req !== exp_req) begin
                n_fail++;
                $display("FAIL rand_req c=%0d: got %b want %b", c, wr_if.wr_req, exp_req);
            end
            if (exp_req) begin
                n_checks++;
                if (wr_if.wr_addr !== exp_e.rd || wr_if.wr_data !== exp_e.data) begin
                    n_fail++;
                    $display("FAIL rand_head c=%0d: got %0d/%h want %0d/%h", c, wr_if.wr_addr,
                             wr_if.wr_data, exp_e.rd, exp_e.data);
                end
            end
            n_checks++;
            if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) || ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_state c=%0d: count=%0d full=%b ovf=%b want %0d %b %b", c,
                         count, full, ovf, q.size(), q.size() == DEPTH, m_ovf);
            end
            consumed = 1'b0;
            if (ack && exp_req) begin
                if (q.size() != 0) void'(q.pop_front());
                else consumed = 1'b1;
            end
            if (v && rd != 5'd0 && !consumed) begin
                if (q.size() < DEPTH) q.push_back(wb_entry_t'{rd: rd, data: d});
                else m_ovf = 1'b1;
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        test_reset();
        test_single_push();
        test_overflow();
        test_full_swap();
        test_zero_reg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mov_wb_64.md
# mov_wb_64

Writeback end of the 64-bit MOV pipeline. Takes the result emerging from the fixed-latency MOV delay line (data, destination register, valid) and writes it into the register file through a write-port request/acknowledge handshake. The MOV pipeline cannot stall, so a small FIFO absorbs results while the register-file port is busy. Overflow is flagged and never silently hidden.

## Interface
- DW, 64, data width of a MOV result.
- AW, 5, destination register index width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  pipeline output carries a result this cycle
- in_data  in  DW  result data
- in_rd  in  AW  destination register
- wr_req  out  1  write request to register file
- wr_addr  out  AW  write address, valid while wr_req
- wr_data  out  DW  write data, valid while wr_req
- wr_ack  in  1  register file accepts the write this cycle
- full  out  1  FIFO holds DEPTH entries
- count  out  $clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky overflow flag

## Operation
- Reset (rst_n low at a clk edge): count=0, wr_req=0, wr_addr=0, wr_data=0, full=0, ovf=0. Pointers go to 0 and FIFO contents are discarded, including during a pending handshake.
- Push: in_valid=1 and in_rd!=0 enqueues {in_rd, in_data}.
- A result with in_rd==0 is discarded. It is not enqueued and does not set ovf.
- Pop: a transfer completes on any clk edge where wr_req=1 and wr_ack=1. The head entry is removed.
- wr_req=1 whenever count>0, subject to the bypass rule below. wr_addr/wr_data show the head entry and stay stable until the transfer.
- A simultaneous push and pop leaves count unchanged. This is allowed when full: the head leaves and the new entry enters.
- Push while full with no pop in the same cycle: the entry is dropped and ovf is set to 1. ovf clears only on reset.
- Writes reach the register file in arrival order. No merging of entries with the same destination.
- Pointers wrap modulo DEPTH. full = (count==DEPTH).

## Timing
- No-bypass latency: in_valid at edge N into an empty FIFO gives wr_req=1 after edge N.
- Ack timing: wr_ack held high gives one write per cycle. The next entry is presented the cycle after each transfer with no bubble.
- Ack ordering: wr_ack while wr_req=0 is ignored. wr_req never drops before ack.
- Registered outputs: wr_req, wr_addr, wr_data, full, count and ovf come from flops when bypass is off.
- Sustained throughput: one entry per cycle in each direction.

## Configuration
- The bypass feature is controlled by MOV_WB_BYPASS_EN.
- Defined:
  - When count==0 and in_valid=1 with in_rd!=0, wr_req, wr_addr and wr_data are driven combinationally from the inputs in the same cycle.
  - If wr_ack=1 in that cycle, the entry is written and never enqueued. Otherwise it is enqueued normally.
  - Zero-cycle latency.
- Undefined: all outputs are registered, with 1-cycle minimum latency as described in Timing.

## Structure
- Package mov_pkg:
  - constants MOV_DW=64, MOV_AW=5, MOV_WB_DEPTH=4
  - typedef of the writeback entry struct {rd, data}
- Sub-module wb_fifo:
  - generic synchronous FIFO: storage, pointers, count, full/empty, and push/pop with the simultaneous-when-full rule
- mov_wb_64 contains:
  - the zero-register filter
  - the handshake glue
  - ovf generation
  - the bypass mux

## Test plan
- Reset while count=3 and wr_req=1 -> next cycle count=0, wr_req=0, ovf=0. A following push of rd=7, data=64'hA5A5 appears correctly.
- Single push of rd=3, data=64'h1111111111111111 with wr_ack tied 1 -> wr_addr=3, wr_data=64'h1111111111111111 for exactly one cycle. Latency is 1 without bypass and 0 with it.
- Push rd=1,2,3,4,5 back-to-back with wr_ack=0 -> full=1 after the 4th push. The 5th is dropped and ovf=1. Then raising wr_ack drains 1,2,3,4 in order and rd=5 is never written.
- With full and wr_ack=1, push rd=9 -> count stays 4, head pops, and rd=9 is written last with no ovf.
- Push with in_rd=0, data=64'hFFFF -> count stays 0, wr_req stays 0, ovf=0.
- wr_ack toggling randomly for 200 cycles under a 50% push rate, with count kept at or below 4 -> writes are in order and match a reference queue, and wr_addr/wr_data are stable while wr_req=1 and wr_ack=0.
